// File: rtl/adaptive_threshold_ctrl.sv
// Raster-scan sequencer and registered compare stage for the adaptive-threshold pipeline.
// Optionally triggers a box-filter pass, then streams one binarised or pass-through pixel per cycle.
module adaptive_threshold_ctrl #(
   parameter int unsigned WIDTH_BITS  = 8,
   parameter int unsigned HEIGHT_BITS = 8,
   parameter int unsigned RD_LATENCY  = 1,
   parameter int unsigned COLOR_BITS  = 3
) (
   input  logic                   clock,
   input  logic                   reset,
   input  logic                   start,
   input  logic [1:0]             cfg_mode,
   input  logic [7:0]             cfg_offset,
   input  logic [7:0]             cfg_global,
   input  logic                   cfg_invert,
   output logic                   filter_start,
   input  logic                   filter_done,
   output logic [WIDTH_BITS-1:0]  oImageCol,
   output logic [HEIGHT_BITS-1:0] oImageRow,
   input  logic [7:0]             iImageData,
   output logic [WIDTH_BITS-1:0]  oThrCol,
   output logic [HEIGHT_BITS-1:0] oThrRow,
   input  logic [7:0]             iThrData,
   output logic [WIDTH_BITS-1:0]  oX,
   output logic [HEIGHT_BITS-1:0] oY,
   output logic [COLOR_BITS-1:0]  oR,
   output logic [COLOR_BITS-1:0]  oG,
   output logic [COLOR_BITS-1:0]  oB,
   output logic                   oWren,
   output logic                   busy,
   output logic                   done,
   output logic [9:0]             LEDR
);

   typedef enum logic [2:0] {StIdle, StFilter, StScan, StDrain, StDone} state_e;

   state_e                 state_q, state_d;
   logic                   first_q, first_d;
   logic [WIDTH_BITS-1:0]  col_q, col_d;
   logic [HEIGHT_BITS-1:0] row_q, row_d;
   logic [1:0]             mode_q, mode_d;
   logic [7:0]             off_q, off_d;
   logic [7:0]             glob_q, glob_d;
   logic                   inv_q, inv_d;

   logic [RD_LATENCY-1:0]  valid_q, valid_d;
   logic [WIDTH_BITS-1:0]  col_pipe_q [RD_LATENCY];
   logic [WIDTH_BITS-1:0]  col_pipe_d [RD_LATENCY];
   logic [HEIGHT_BITS-1:0] row_pipe_q [RD_LATENCY];
   logic [HEIGHT_BITS-1:0] row_pipe_d [RD_LATENCY];

   logic                   wren_q, wren_d;
   logic [WIDTH_BITS-1:0]  x_q, x_d;
   logic [HEIGHT_BITS-1:0] y_q, y_d;
   logic [COLOR_BITS-1:0]  r_q, r_d, g_q, g_d, b_q, b_d;

   logic [7:0]             thr_sel;
   logic signed [9:0]      sum;
   logic                   white;

   always_comb begin
      state_d = state_q;
      first_d = 1'b0;
      col_d   = col_q;
      row_d   = row_q;
      mode_d  = mode_q;
      off_d   = off_q;
      glob_d  = glob_q;
      inv_d   = inv_q;
      case (state_q)
         StIdle, StDone: begin
            if (start) begin
               mode_d = cfg_mode;
               off_d  = cfg_offset;
               glob_d = cfg_global;
               inv_d  = cfg_invert;
               if (cfg_mode == 2'd1 || cfg_mode == 2'd2) begin
                  state_d = StScan;
               end else begin
                  state_d = StFilter;
                  first_d = 1'b1;
               end
            end
         end
         // A filter_done coinciding with our own start pulse is stale, so skip it.
         StFilter: if (!first_q && filter_done) state_d = StScan;
         StScan: begin
            col_d = col_q + WIDTH_BITS'(1);
            if (&col_q) row_d = row_q + HEIGHT_BITS'(1);
            if (&col_q && &row_q) state_d = StDrain;
         end
         StDrain: if (wren_q && !(|valid_q)) state_d = StDone;
         default: state_d = StIdle;
      endcase
   end

   always_comb begin
      valid_d       = valid_q;
      col_pipe_d    = col_pipe_q;
      row_pipe_d    = row_pipe_q;
      valid_d[0]    = (state_q == StScan);
      col_pipe_d[0] = col_q;
      row_pipe_d[0] = row_q;
      for (int i = 1; i < int'(RD_LATENCY); i++) begin
         valid_d[i]    = valid_q[i-1];
         col_pipe_d[i] = col_pipe_q[i-1];
         row_pipe_d[i] = row_pipe_q[i-1];
      end
   end

   // Sum is 10-bit signed so pixel + offset never wraps.
   always_comb begin
      thr_sel = (mode_q == 2'd1) ? glob_q : iThrData;
      sum     = $signed({2'b00, iImageData}) + $signed({{2{off_q[7]}}, off_q});
      white   = (sum > $signed({2'b00, thr_sel})) ^ inv_q;
   end

   always_comb begin
      wren_d = valid_q[RD_LATENCY-1];
      x_d    = x_q;
      y_d    = y_q;
      r_d    = r_q;
      g_d    = g_q;
      b_d    = b_q;
      if (valid_q[RD_LATENCY-1]) begin
         x_d = col_pipe_q[RD_LATENCY-1];
         y_d = row_pipe_q[RD_LATENCY-1];
         if (mode_q == 2'd2) begin
            r_d = iImageData[7 -: COLOR_BITS];
            g_d = iImageData[7 -: COLOR_BITS];
            b_d = iImageData[7 -: COLOR_BITS];
         end else begin
            r_d = {COLOR_BITS{white}};
            g_d = {COLOR_BITS{white}};
            b_d = {COLOR_BITS{white}};
         end
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q    <= StIdle;
         first_q    <= 1'b0;
         col_q      <= '0;
         row_q      <= '0;
         mode_q     <= '0;
         off_q      <= '0;
         glob_q     <= '0;
         inv_q      <= 1'b0;
         valid_q    <= '0;
         col_pipe_q <= '{default: '0};
         row_pipe_q <= '{default: '0};
         wren_q     <= 1'b0;
         x_q        <= '0;
         y_q        <= '0;
         r_q        <= '0;
         g_q        <= '0;
         b_q        <= '0;
      end else begin
         state_q    <= state_d;
         first_q    <= first_d;
         col_q      <= col_d;
         row_q      <= row_d;
         mode_q     <= mode_d;
         off_q      <= off_d;
         glob_q     <= glob_d;
         inv_q      <= inv_d;
         valid_q    <= valid_d;
         col_pipe_q <= col_pipe_d;
         row_pipe_q <= row_pipe_d;
         wren_q     <= wren_d;
         x_q        <= x_d;
         y_q        <= y_d;
         r_q        <= r_d;
         g_q        <= g_d;
         b_q        <= b_d;
      end
   end

   always_comb begin
      LEDR    = '0;
      LEDR[0] = (state_q == StIdle);
      LEDR[1] = (state_q == StFilter);
      LEDR[2] = (state_q == StScan) || (state_q == StDrain);
      LEDR[3] = (state_q == StDone);
   end

   assign filter_start = (state_q == StFilter) && first_q;
   assign busy         = (state_q == StFilter) || (state_q == StScan) || (state_q == StDrain);
   assign done         = (state_q == StDone);
   assign oImageCol    = col_q;
   assign oImageRow    = row_q;
   assign oThrCol      = col_q;
   assign oThrRow      = row_q;
   assign oX           = x_q;
   assign oY           = y_q;
   assign oR           = r_q;
   assign oG           = g_q;
   assign oB           = b_q;
   assign oWren        = wren_q;

endmodule

// File: tb/tb_adaptive_threshold_ctrl.sv
// Scoreboard bench for adaptive_threshold_ctrl: a 4x4 instance with read latency 1 (a)
// and one with read latency 3 (b), each fed by a table-driven memory model.
module tb_adaptive_threshold_ctrl;

   typedef struct packed {
      logic [1:0] x;
      logic [1:0] y;
      logic [2:0] r;
      logic [2:0] g;
      logic [2:0] b;
   } exp_t;

   logic       clk;
   logic       rst_a, rst_b, start_a, start_b;
   logic [1:0] cfg_mode;
   logic [7:0] cfg_offset, cfg_global;
   logic       cfg_invert, filter_done;

   logic       filter_start_a, filter_start_b;
   logic [1:0] img_col_a, img_row_a, thr_col_a, thr_row_a, ox_a, oy_a;
   logic [1:0] img_col_b, img_row_b, thr_col_b, thr_row_b, ox_b, oy_b;
   logic [7:0] img_data_a, thr_data_a;
   logic [7:0] img_b_q [3];
   logic [7:0] thr_b_q [3];
   logic [2:0] or_a, og_a, ob_a, or_b, og_b, ob_b;
   logic       wren_a, busy_a, done_a, wren_b, busy_b, done_b;
   logic [9:0] ledr_a, ledr_b;

   logic [7:0] img_tab [16];
   logic [7:0] thr_tab [16];
   exp_t       qa[$];
   exp_t       qb[$];
   int         n_tests = 0;
   int         n_fail = 0;
   int         fs_cnt = 0;

   adaptive_threshold_ctrl #(
      .WIDTH_BITS(2), .HEIGHT_BITS(2), .RD_LATENCY(1), .COLOR_BITS(3)
   ) dut_a (
      .clock(clk), .reset(rst_a), .start(start_a), .cfg_mode(cfg_mode),
      .cfg_offset(cfg_offset), .cfg_global(cfg_global), .cfg_invert(cfg_invert),
      .filter_start(filter_start_a), .filter_done(filter_done),
      .oImageCol(img_col_a), .oImageRow(img_row_a), .iImageData(img_data_a),
      .oThrCol(thr_col_a), .oThrRow(thr_row_a), .iThrData(thr_data_a),
      .oX(ox_a), .oY(oy_a), .oR(or_a), .oG(og_a), .oB(ob_a), .oWren(wren_a),
      .busy(busy_a), .done(done_a), .LEDR(ledr_a)
   );

   adaptive_threshold_ctrl #(
      .WIDTH_BITS(2), .HEIGHT_BITS(2), .RD_LATENCY(3), .COLOR_BITS(3)
   ) dut_b (
      .clock(clk), .reset(rst_b), .start(start_b), .cfg_mode(cfg_mode),
      .cfg_offset(cfg_offset), .cfg_global(cfg_global), .cfg_invert(cfg_invert),
      .filter_start(filter_start_b), .filter_done(1'b0),
      .oImageCol(img_col_b), .oImageRow(img_row_b), .iImageData(img_b_q[2]),
      .oThrCol(thr_col_b), .oThrRow(thr_row_b), .iThrData(thr_b_q[2]),
      .oX(ox_b), .oY(oy_b), .oR(or_b), .oG(og_b), .oB(ob_b), .oWren(wren_b),
      .busy(busy_b), .done(done_b), .LEDR(ledr_b)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Memory models: latency 1 for a, a 3-deep chain for b.
   always @(posedge clk) begin
      img_data_a <= img_tab[{img_row_a, img_col_a}];
      thr_data_a <= thr_tab[{thr_row_a, thr_col_a}];
      img_b_q[0] <= img_tab[{img_row_b, img_col_b}];
      thr_b_q[0] <= thr_tab[{thr_row_b, thr_col_b}];
      img_b_q[1] <= img_b_q[0];
      thr_b_q[1] <= thr_b_q[0];
      img_b_q[2] <= img_b_q[1];
      thr_b_q[2] <= thr_b_q[1];
   end

   task automatic check(input string name, input int act, input int exp);
      n_tests++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // Monitors: pop one expected pixel per write strobe.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (wren_a) begin
            check("write_expected_a", int'(qa.size() > 0), 1);
            if (qa.size() > 0) begin
               e = qa.pop_front();
               check("pixel_a", int'({ox_a, oy_a, or_a, og_a, ob_a}), int'(e));
            end
         end
         if (filter_start_a) fs_cnt++;
      end
   end

   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (wren_b) begin
            check("write_expected_b", int'(qb.size() > 0), 1);
            if (qb.size() > 0) begin
               e = qb.pop_front();
               check("pixel_b", int'({ox_b, oy_b, or_b, og_b, ob_b}), int'(e));
            end
         end
      end
   end

   task automatic push_exp(input bit b, input logic [1:0] mode, input logic [7:0] off,
                           input logic [7:0] glob, input logic inv);
      for (int i = 0; i < 16; i++) begin
         exp_t       e;
         int         s, thr;
         logic       w;
         logic [2:0] c;
         if (mode == 2'd2) begin
            c = img_tab[i][7:5];
         end else begin
            s   = int'(img_tab[i]) + int'($signed(off));
            thr = (mode == 2'd1) ? int'(glob) : int'(thr_tab[i]);
            w   = (s > thr) ? ~inv : inv;
            c   = w ? 3'b111 : 3'b000;
         end
         e.x = 2'(i % 4);
         e.y = 2'(i / 4);
         e.r = c;
         e.g = c;
         e.b = c;
         if (b) qb.push_back(e);
         else qa.push_back(e);
      end
   endtask

   task automatic kick(input bit b, input logic [1:0] mode, input logic [7:0] off,
                       input logic [7:0] glob, input logic inv);
      @(negedge clk);
      cfg_mode   = mode;
      cfg_offset = off;
      cfg_global = glob;
      cfg_invert = inv;
      if (b) start_b = 1'b1;
      else start_a = 1'b1;
      @(negedge clk);
      start_a = 1'b0;
      start_b = 1'b0;
   endtask

   // Called in the first SCAN cycle; lat is the expected cycle count to the first write.
   task automatic wait_writes(input bit b, input int lat);
      int n;
      n = 0;
      while (!(b ? wren_b : wren_a) && n < 200) begin
         @(negedge clk);
         n++;
      end
      check("first_write_seen", int'(b ? wren_b : wren_a), 1);
      check("first_write_delay", n, lat);
      n = 0;
      while ((b ? wren_b : wren_a) && n < 100) begin
         @(negedge clk);
         n++;
      end
      check("contiguous_writes", n, 16);
      check("done_after_last", int'(b ? done_b : done_a), 1);
      check("busy_after_last", int'(b ? busy_b : busy_a), 0);
      check("ledr_done", int'(b ? ledr_b : ledr_a), 8);
      check("queue_drained", b ? qb.size() : qa.size(), 0);
   endtask

   task automatic run(input bit b, input logic [1:0] mode, input logic [7:0] off,
                      input logic [7:0] glob, input logic inv);
      int fs0;
      fs0 = fs_cnt;
      push_exp(b, mode, off, glob, inv);
      kick(b, mode, off, glob, inv);
      check("busy_after_start", int'(b ? busy_b : busy_a), 1);
      if (!b && (mode == 2'd0 || mode == 2'd3)) begin
         check("filter_pulse", int'(filter_start_a), 1);
         check("filter_ledr", int'(ledr_a), 2);
         filter_done = 1'b1;
         @(negedge clk);
         filter_done = 1'b0;
         check("filter_done_in_pulse_ignored", int'(ledr_a), 2);
         repeat (5) @(negedge clk);
         check("no_scan_before_filter_done", int'({ledr_a, wren_a}), 2 << 1);
         filter_done = 1'b1;
         @(negedge clk);
         filter_done = 1'b0;
         check("scan_after_filter_done", int'(ledr_a), 4);
         check("filter_pulse_count", fs_cnt - fs0, 1);
      end
      check("scan_entry_addr",
            int'(b ? {img_row_b, img_col_b} : {img_row_a, img_col_a}), 0);
      wait_writes(b, b ? 4 : 2);
   endtask

   initial begin
      int n;
      rst_a = 1'b1;
      rst_b = 1'b1;
      start_a = 1'b0;
      start_b = 1'b0;
      cfg_mode = '0;
      cfg_offset = '0;
      cfg_global = '0;
      cfg_invert = 1'b0;
      filter_done = 1'b0;
      for (int i = 0; i < 16; i++) begin
         img_tab[i] = 8'(16 * i);
         thr_tab[i] = 8'd100;
      end
      repeat (3) @(negedge clk);
      check("rst_wren", int'(wren_a), 0);
      check("rst_ledr", int'(ledr_a), 1);
      check("rst_busy_done_fs", int'({busy_a, done_a, filter_start_a}), 0);
      check("rst_xy_rgb", int'({ox_a, oy_a, or_a, og_a, ob_a}), 0);
      check("rst_addr", int'({img_col_a, img_row_a, thr_col_a, thr_row_a}), 0);
      check("rst_ledr_b", int'(ledr_b), 1);
      rst_a = 1'b0;
      rst_b = 1'b0;

      // Global threshold 128 over a ramp 0..240.
      run(0, 2'd1, 8'h00, 8'd128, 1'b0);

      // Adaptive, offset -5, threshold RAM 100: 105 -> black, 106 -> white.
      for (int i = 0; i < 16; i++) img_tab[i] = 8'(100 + i);
      run(0, 2'd0, 8'hFB, 8'd0, 1'b0);
      // Reserved mode behaves as adaptive.
      run(0, 2'd3, 8'hFB, 8'd0, 1'b1);

      // Offset extremes: no 8-bit wrap, signed compare.
      for (int i = 0; i < 16; i++) begin
         img_tab[i] = (i % 2 == 0) ? 8'hFF : 8'h00;
         thr_tab[i] = 8'hFF;
      end
      run(0, 2'd0, 8'h7F, 8'd0, 1'b0);
      run(0, 2'd0, 8'h7F, 8'd0, 1'b1);
      run(0, 2'd1, 8'h80, 8'd0, 1'b0);
      run(0, 2'd1, 8'h80, 8'd0, 1'b1);

      // Pass-through ignores offset and invert.
      for (int i = 0; i < 16; i++) img_tab[i] = 8'(17 * i + 3);
      img_tab[0] = 8'hB4;
      run(0, 2'd2, 8'h55, 8'd0, 1'b1);

      // start held into the first SCAN cycle with new cfg is ignored.
      for (int i = 0; i < 16; i++) img_tab[i] = 8'(16 * i);
      push_exp(0, 2'd1, 8'h00, 8'd128, 1'b0);
      kick(0, 2'd1, 8'h00, 8'd128, 1'b0);
      cfg_global = 8'd0;
      cfg_invert = 1'b1;
      start_a = 1'b1;
      @(negedge clk);
      start_a = 1'b0;
      check("start_in_scan_ignored", int'(ledr_a), 4);
      wait_writes(0, 1);
      // Restart from DONE picks up the new cfg.
      run(0, 2'd1, 8'h00, 8'd0, 1'b1);

      // start and reset together: reset wins.
      @(negedge clk);
      start_a = 1'b1;
      rst_a = 1'b1;
      @(negedge clk);
      start_a = 1'b0;
      rst_a = 1'b0;
      check("reset_beats_start", int'({ledr_a, wren_a, done_a}), 1 << 2);

      // Latency-3 instance: reset mid-scan at pixel 5, then rescan.
      push_exp(1, 2'd1, 8'h00, 8'd128, 1'b0);
      kick(1, 2'd1, 8'h00, 8'd128, 1'b0);
      n = 0;
      while ({img_row_b, img_col_b} != 4'd5 && n < 50) begin
         @(negedge clk);
         n++;
      end
      check("reached_pixel5", int'({img_row_b, img_col_b}), 5);
      rst_b = 1'b1;
      #1 qb.delete();
      @(negedge clk);
      rst_b = 1'b0;
      check("mid_scan_reset_ledr", int'(ledr_b), 1);
      n = 0;
      repeat (10) begin
         if (wren_b) n++;
         @(negedge clk);
      end
      check("no_write_after_reset", n, 0);
      check("idle_after_reset", int'(ledr_b), 1);
      run(1, 2'd1, 8'h00, 8'd128, 1'b0);

      repeat (3) @(negedge clk);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish, tests=%0d failed=%0d",
               n_tests, n_fail);
      $fatal(1, "watchdog");
   end

endmodule
